mem_access_stage: RTL and testbench

- Memory-stage access controller. Takes the ALU address and store data from the E/M pipeline register and runs one data-memory transaction per instruction over a req/ack bus.
- Returns load data that is byte/half aligned and extended, ready for the M/RB pipeline register as mem_rdata_M.
- Stalls the pipeline while a transaction is outstanding. Flags misaligned, illegal and timed-out accesses.

---
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-stage access controller: one req/ack data-memory transaction per
// load/store, with store lane formatting, load alignment/extension and error reporting.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_M,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] rs2_data_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_rdata_M,
  output logic        mem_stall,
  output logic [1:0]  mem_err_M
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic              access, f3_ok, misal, legal, timeout_hit;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, rd_shift, ld_fmt;
  logic [15:0]       half_sel;

  assign access      = valid_M & (mem_rd_M | mem_wr_M);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    f3_ok = 1'b0;
    if (mem_rd_M) begin
      case (funct3_M)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else if (mem_wr_M) begin
      case (funct3_M)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
  end

  assign misal = ((funct3_M[1:0] == 2'b01) & alu_result_M[0]) |
                 ((funct3_M[1:0] == 2'b10) & (|alu_result_M[1:0]));
  assign legal = access & f3_ok & ~misal;

  // Store lane placement; loads always read the full word.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = 32'h0;
    if (mem_wr_M) begin
      case (funct3_M[1:0])
        2'b00: begin
          be_c    = 4'b0001 << alu_result_M[1:0];
          wdata_c = {4{rs2_data_M[7:0]}};
        end
        2'b01: begin
          be_c    = alu_result_M[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{rs2_data_M[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = rs2_data_M;
        end
      endcase
    end
  end

  assign rd_shift = dmem_rdata >> {off_q, 3'b000};
  assign half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_fmt = {24'h0, rd_shift[7:0]};
      3'b101:  ld_fmt = {16'h0, half_sel};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = legal;
        if (legal) state_nxt = REQ;
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      cnt         <= '0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      mem_rdata_M <= 32'h0;
      mem_err_M   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_wr_M;
            dmem_addr  <= {alu_result_M[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            cnt        <= '0;
            off_q      <= alu_result_M[1:0];
            f3_q       <= funct3_M;
          end else if (access) begin
            mem_rdata_M <= 32'h0;
            mem_err_M   <= f3_ok ? 2'b01 : 2'b10;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            mem_rdata_M <= dmem_we ? 32'h0 : ld_fmt;
            mem_err_M   <= 2'b00;
          end else if (timeout_hit) begin
            dmem_req    <= 1'b0;
            mem_rdata_M <= 32'h0;
            mem_err_M   <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected bus requests,
// completions and state probes; a negedge monitor pops and compares them.
module tb_mem_access_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, valid_M, mem_rd_M, mem_wr_M;
  logic [2:0]  funct3_M;
  logic [31:0] alu_result_M, rs2_data_M;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_rdata_M;
  logic [3:0]  dmem_be;
  logic [1:0]  mem_err_M;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .valid_M(valid_M), .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M),
    .funct3_M(funct3_M), .alu_result_M(alu_result_M), .rs2_data_M(rs2_data_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_rdata_M(mem_rdata_M), .mem_stall(mem_stall), .mem_err_M(mem_err_M)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} bus_t;
  typedef struct {logic [31:0] rdata; logic [1:0] err; int nreq; int nstall;} res_t;
  typedef struct {
    logic req; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    logic stall; logic [31:0] rdata; logic [1:0] err;
  } snap_t;

  bus_t  bq[$];
  res_t  rq[$];
  snap_t pq[$];
  int    checks = 0, failures = 0;
  bit    fin = 1'b0;
  logic  prev_req = 1'b0, flag = 1'b0;
  int    nreq = 0, nstall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a completion is reported one sample after an access is seen with no stall.
  always @(negedge clk) begin : mon
    res_t  r;
    bus_t  b;
    snap_t s;
    if (rst) begin
      nreq = 0; nstall = 0; flag = 1'b0;
    end else begin
      if (flag) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL completion_unexpected: got rdata %h err %0d expected none", mem_rdata_M, mem_err_M);
        end else begin
          r = rq.pop_front();
          chk("rdata", mem_rdata_M, r.rdata);
          chk("err", 32'(mem_err_M), 32'(r.err));
          chk("req_cycles", nreq, r.nreq);
          chk("stall_cycles", nstall, r.nstall);
        end
        nreq = 0; nstall = 0;
      end
      nreq   += int'(dmem_req);
      nstall += int'(mem_stall);
      flag    = valid_M & (mem_rd_M | mem_wr_M) & ~mem_stall;
    end
    if (dmem_req && !prev_req) begin
      if (bq.size() == 0) begin
        checks++; failures++;
        $display("FAIL bus_unexpected: got req addr %h expected no request", dmem_addr);
      end else begin
        b = bq.pop_front();
        chk("bus_we", 32'(dmem_we), 32'(b.we));
        chk("bus_be", 32'(dmem_be), 32'(b.be));
        chk("bus_addr", dmem_addr, b.addr);
        chk("bus_wdata", dmem_wdata, b.wdata);
      end
    end
    prev_req = dmem_req;
    if (pq.size() != 0) begin
      s = pq.pop_front();
      chk("probe_req", 32'(dmem_req), 32'(s.req));
      chk("probe_we", 32'(dmem_we), 32'(s.we));
      chk("probe_be", 32'(dmem_be), 32'(s.be));
      chk("probe_addr", dmem_addr, s.addr);
      chk("probe_wdata", dmem_wdata, s.wdata);
      chk("probe_stall", 32'(mem_stall), 32'(s.stall));
      chk("probe_rdata", mem_rdata_M, s.rdata);
      chk("probe_err", 32'(mem_err_M), 32'(s.err));
    end
    if (fin) begin
      chk("queues_drained", 32'(rq.size() + bq.size() + pq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // ack_at: REQ cycle (1-based) carrying ack; 0 = never ack (timeout).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input int ack_at, input logic [31:0] word, input bit legal,
                        input logic [31:0] eaddr, input logic [3:0] ebe,
                        input logic [31:0] ewdata, input logic [31:0] erdata,
                        input logic [1:0] eerr);
    @(posedge clk); #1;
    valid_M = 1'b1; mem_rd_M = rd; mem_wr_M = wr; funct3_M = f3;
    alu_result_M = addr; rs2_data_M = rs2;
    if (legal) begin
      bq.push_back('{wr, ebe, eaddr, ewdata});
      rq.push_back('{erdata, eerr, (ack_at == 0) ? TO : ack_at, (ack_at == 0) ? TO + 1 : ack_at + 1});
    end else begin
      rq.push_back('{erdata, eerr, 0, 0});
    end
    if (!legal) begin
      @(posedge clk); #1;
    end else if (ack_at == 0) begin
      repeat (TO + 2) @(posedge clk);
      #1;
    end else begin
      repeat (ack_at) @(posedge clk);
      #1 dmem_ack = 1'b1; dmem_rdata = word;
      @(posedge clk); #1 dmem_ack = 1'b0;
      @(posedge clk); #1;
    end
    valid_M = 1'b0; mem_rd_M = 1'b0; mem_wr_M = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_M = 1'b0; mem_rd_M = 1'b0; mem_wr_M = 1'b0; funct3_M = 3'b000;
    alu_result_M = 32'h0; rs2_data_M = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pq.push_back('{default: '0});

    //      rd   wr   f3      addr          rs2           ack word          legal eaddr         ebe      ewdata        erdata        err
    access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        3, 32'hDEAD_BEEF, 1, 32'h0000_0104, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2'b00);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h80FF_1234, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 2'b00);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        1, 32'h80FF_1234, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080, 2'b00);
    access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        1, 32'h80FF_1234, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_80FF, 2'b00);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        1, 32'h80FF_1234, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_1234, 2'b00);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,         2'b01);
    access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,         2'b10);
    access(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,         2'b01);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,        2, 32'h1122_3344, 1, 32'h0000_0500, 4'b1111, 32'h0,        32'h1122_3344, 2'b00);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        0, 32'h0,         1, 32'h0000_0400, 4'b1111, 32'h0,        32'h0,         2'b11);

    // Late ack while idle must not disturb the timeout result.
    @(posedge clk); #1 dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1 dmem_ack = 1'b0;
    pq.push_back('{1'b0, 1'b0, 4'b1111, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 2'b11});

    access(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 1, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0, 2'b00);
    access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 1, 32'hFFFF_FFFF, 1, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0, 2'b00);
    access(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 2, 32'hFFFF_FFFF, 1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0, 2'b00);
    access(1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h0,        0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,         2'b10);

    // Reset in the second REQ cycle, then a late ack.
    @(posedge clk); #1;
    valid_M = 1'b1; mem_rd_M = 1'b1; funct3_M = 3'b010; alu_result_M = 32'h0000_0600;
    bq.push_back('{1'b0, 4'b1111, 32'h0000_0600, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1; valid_M = 1'b0; mem_rd_M = 1'b0;
    @(posedge clk); #1 rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h55AA_55AA;
    pq.push_back('{default: '0});
    @(posedge clk); #1 dmem_ack = 1'b0;
    pq.push_back('{default: '0});

    repeat (3) @(posedge clk);
    #1 fin = 1'b1;
  end
endmodule
